// File: rtl/s2p_align_ctrl.sv
// s2p_align_ctrl: word-alignment controller for the serial-to-parallel receive path.
// Shifts in an LSB-first serial stream, hunts for SYNC_WORD to fix the word
// boundary, verifies lock over LOCK_CNT aligned syncs, then emits aligned
// parallel words with a one-cycle valid strobe. Falls back to HUNT after
// LOSS_CNT misaligned sync detections in LOCK, or on a realign pulse.
module s2p_align_ctrl #(
  parameter int               WIDTH     = 10,
  parameter logic [WIDTH-1:0] SYNC_WORD = 10'h17C,
  parameter int               LOCK_CNT  = 3,
  parameter int               LOSS_CNT  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dext,
  input  logic             bit_en,
  input  logic             realign,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             sync_det,
  output logic             locked,
  output logic [1:0]       state
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_t;

  state_t           st_q, st_d;
  logic [WIDTH-1:0] sh, shn;
  logic [CW-1:0]    cnt, cnt_d;
  logic [GW-1:0]    good_cnt, good_d;
  logic [MW-1:0]    miss_cnt, miss_d;
  logic             match, boundary, cap;

  // Next shift-register value: new bit enters at the top, so after WIDTH
  // bits the first serial bit sits at bit 0. All matching looks at this
  // value so detection lands on the edge that shifts in the last bit.
  assign shn      = {dext, sh[WIDTH-1:1]};
  assign match    = (shn == SYNC_WORD);
  assign boundary = bit_en && (cnt == CW'(WIDTH - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; combinational blocks use blocking ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= HUNT;
    else     st_q <= st_d;
  end

  // Next-state and counter-update decode for HUNT / VERIFY / LOCK.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    st_d   = st_q;
    cnt_d  = cnt;
    good_d = good_cnt;
    miss_d = miss_cnt;
    cap    = 1'b0;
    if (realign) begin
      st_d   = HUNT;
      cnt_d  = '0;
      good_d = '0;
      miss_d = '0;
    end else if (bit_en) begin
      cnt_d = boundary ? '0 : cnt + CW'(1);
      unique case (st_q)
        HUNT: begin
          if (match) begin
            // New detection fixes the word phase from this edge.
            cnt_d  = '0;
            good_d = GW'(1);
            miss_d = '0;
            st_d   = (LOCK_CNT == 1) ? LOCK : VERIFY;
          end
        end
        VERIFY: begin
          if (boundary) begin
            if (match) begin
              good_d = good_cnt + GW'(1);
              if (good_d == GW'(LOCK_CNT)) begin
                st_d = LOCK;
                cap  = 1'b1;
              end
            end else begin
              st_d   = HUNT;
              good_d = '0;
            end
          end
        end
        LOCK: begin
          if (boundary) begin
            cap = 1'b1;
            if (match) miss_d = '0;
          end else if (match) begin
            // A sync off the word boundary means the phase may have slipped.
            miss_d = miss_cnt + MW'(1);
            if (miss_d == MW'(LOSS_CNT)) begin
              st_d   = HUNT;
              cnt_d  = '0;
              good_d = '0;
              miss_d = '0;
            end
          end
        end
        default: begin
          st_d   = HUNT;
          cnt_d  = '0;
          good_d = '0;
          miss_d = '0;
        end
      endcase
    end
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    locked = (st_q == LOCK);
    state  = st_q;
  end

  // Datapath: shift register, phase/verify/loss counters, word capture and strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh         <= '0;
      cnt        <= '0;
      good_cnt   <= '0;
      miss_cnt   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sync_det   <= 1'b0;
    end else begin
      if (bit_en) sh <= shn;
      cnt        <= cnt_d;
      good_cnt   <= good_d;
      miss_cnt   <= miss_d;
      if (cap) dout <= shn;
      dout_valid <= cap;
      sync_det   <= cap && match;
    end
  end

endmodule
